// File: rtl/bus_source_arbiter.sv
// -----------------------------------------------------------------------------
// bus_source_arbiter
//
// Round-robin arbiter for the shared internal 32-bit bus. Up to N_SRC sources
// (R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C, ...) request the bus. One
// owner at a time is granted. Between two owners there is always one dead
// turnaround cycle. An owner that keeps the bus for HOLD_MAX consecutive cycles
// has its grant revoked.
//
// Parameters
//   N_SRC     number of arbitrated sources (1..32); higher req bits are ignored
//   HOLD_MAX  maximum consecutive grant cycles per owner (1..255), 0 = no limit
//
// Ports
//   clk          system clock, rising edge
//   clr          synchronous active-low reset
//   req[31:0]    level-sensitive request, bit i = source i
//   release_bus  current owner is finished (only looked at while granted).
//                `release` is a reserved word in SystemVerilog, so the port
//                carries this name instead.
//   grant[31:0]  one-hot bus-out select for the 32-to-5 encoder, 0 when idle
//   grant_id     index of the current owner, 5'd31 when idle
//   busy         high while a source owns the bus
//   timeout      one-cycle pulse after a grant was revoked by HOLD_MAX
//
// Every output is a flop. The next-state logic computes the next owner, and
// the output logic decodes that next owner into next-cycle grant values.
// -----------------------------------------------------------------------------
module bus_source_arbiter #(
  parameter int N_SRC    = 24,
  parameter int HOLD_MAX = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] req,
  input  logic        release_bus,
  output logic [31:0] grant,
  output logic [4:0]  grant_id,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Sources at or above N_SRC do not exist and can never win.
  localparam logic [31:0] SRC_MASK = (N_SRC >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << N_SRC) - 32'd1);
  localparam logic [7:0]  HOLD_LIM = 8'(HOLD_MAX);
  localparam logic [4:0]  NO_OWNER = 5'd31;
  localparam logic [5:0]  N_SRC_W  = 6'(N_SRC);

  state_t      state_q, state_d;
  logic [4:0]  owner_q, owner_d;
  logic [4:0]  ptr_q,   ptr_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic        timeout_d;

  logic [31:0] grant_d;
  logic [4:0]  grant_id_d;
  logic        busy_d;

  logic [31:0] req_eff;
  logic        owner_req;
  logic        hold_hit;
  logic        win_found;
  logic [4:0]  win_idx;
  logic [5:0]  scan_sum;
  logic [4:0]  scan_idx;
  logic [4:0]  ptr_after_owner;

  assign req_eff   = req & SRC_MASK;
  assign owner_req = req_eff[owner_q];
  assign hold_hit  = (HOLD_MAX != 0) && (cnt_q == HOLD_LIM);

  // The pointer moves past the owner that just left, wrapping at N_SRC.
  assign ptr_after_owner = (({1'b0, owner_q} + 6'd1) >= N_SRC_W) ? 5'd0
                                                                  : owner_q + 5'd1;

  // Rotating priority search: the first requester at or after ptr, wrapping
  // modulo N_SRC. The 6-bit sum keeps ptr+off from overflowing before the wrap.
  always_comb begin
    // NOTE: every variable gets a default at the top of a combinational block,
    // so no path can leave it unassigned and infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int off = 0; off < N_SRC; off++) begin
      scan_sum = {1'b0, ptr_q} + 6'(off);
      if (scan_sum >= N_SRC_W) begin
        scan_sum = scan_sum - N_SRC_W;
      end
      scan_idx = scan_sum[4:0];
      if (!win_found && req_eff[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          owner_d = win_idx;
          cnt_d   = 8'd1;
        end
      end

      GRANT: begin
        // Exit priority: release, then withdrawn request, then hold limit.
        // Only the last one reports a timeout.
        if (release_bus || !owner_req || hold_hit) begin
          state_d   = IDLE;
          ptr_d     = ptr_after_owner;
          cnt_d     = '0;
          timeout_d = !release_bus && owner_req;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: decodes the next state into the values the output flops load.
  always_comb begin
    grant_d    = '0;
    grant_id_d = NO_OWNER;
    busy_d     = 1'b0;
    if (state_d == GRANT) begin
      grant_d[owner_d] = 1'b1;
      grant_id_d       = owner_d;
      busy_d           = 1'b1;
    end
  end

  // State and output registers. A reset drops the grant at the same edge and
  // never raises timeout.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its input from before the edge regardless of statement order.
    if (!clr) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant    <= '0;
      grant_id <= NO_OWNER;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant    <= grant_d;
      grant_id <= grant_id_d;
      busy     <= busy_d;
      timeout  <= timeout_d;
    end
  end

  // Bus-safety invariants.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!clr)
    $onehot0(grant));

  a_grant_id_agree : assert property (@(posedge clk) disable iff (!clr)
    (grant == '0) ? (grant_id == NO_OWNER) : (grant == (32'd1 << grant_id)));

  a_grant_in_range : assert property (@(posedge clk) disable iff (!clr)
    (grant & ~SRC_MASK) == '0);

  a_busy_matches : assert property (@(posedge clk) disable iff (!clr)
    busy == (grant != '0));

endmodule

// File: tb/tb_bus_source_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_source_arbiter
//
// Directed scenarios with hand-derived expectations, followed by randomized
// traffic checked against a behavioural model. The model tracks the owner as
// an integer (-1 = none) and applies the arbitration rules arithmetically.
// -----------------------------------------------------------------------------
module tb_bus_source_arbiter;

  localparam int N_SRC    = 24;
  localparam int HOLD_MAX = 15;
  localparam logic [31:0] MASK = (32'd1 << N_SRC) - 32'd1;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] req = '0;
  logic        rel = 1'b0;
  logic [31:0] grant;
  logic [4:0]  grant_id;
  logic        busy;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_to    = 1'b0;

  bus_source_arbiter #(.N_SRC(N_SRC), .HOLD_MAX(HOLD_MAX)) dut (
    .clk         (clk),
    .clr         (clr),
    .req         (req),
    .release_bus (rel),
    .grant       (grant),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Applies the arbitration rules to the inputs present at a rising edge.
  function automatic void model_edge();
    logic [31:0] eff;
    bit found;
    bit leave;
    eff  = req & MASK;
    m_to = 1'b0;
    if (!clr) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
        int s;
        s = (m_ptr + k) % N_SRC;
        if (!found && eff[s]) begin
          found   = 1'b1;
          m_owner = s;
          m_cnt   = 1;
        end
      end
    end else begin
      leave = rel || !eff[m_owner] || (HOLD_MAX != 0 && m_cnt == HOLD_MAX);
      if (leave) begin
        m_to    = !rel && eff[m_owner];
        m_ptr   = (m_owner + 1) % N_SRC;
        m_owner = -1;
      end else if (m_cnt < 255) begin
        m_cnt++;
      end
    end
  endfunction

  // One rising edge with the current inputs; returns 1 ns after the edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    req = '0;
    rel = 1'b0;
    cycle();
    clr = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    req = 32'hFFFF_FFFF;
    rel = 1'b0;
    cycle();
    cycle();
    n_cmp++;
    if ({grant, grant_id, busy, timeout} !== {32'h0, 5'd31, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: grant=%h id=%0d busy=%b to=%b, expected 0/31/0/0",
               grant, grant_id, busy, timeout);
    end
    clr = 1'b1;
    cycle();
    n_cmp++;
    if (grant !== 32'h1 || grant_id !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_first_grant: grant=%h id=%0d, expected 00000001/0",
               grant, grant_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 32'h10;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (grant !== 32'h10 || grant_id !== 5'd4 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL single_hold[%0d]: grant=%h id=%0d busy=%b, expected 00000010/4/1",
                 i, grant, grant_id, busy);
      end
    end
    rel = 1'b1;
    cycle();
    rel = 1'b0;
    n_cmp++;
    if (grant !== 32'h0 || grant_id !== 5'd31 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL single_turnaround: grant=%h id=%0d to=%b, expected 0/31/0",
               grant, grant_id, timeout);
    end
    cycle();
    n_cmp++;
    if (grant !== 32'h10) begin
      n_bad++;
      $display("FAIL single_regrant: grant=%h, expected 00000010", grant);
    end
  endtask

  task automatic test_round_robin();
    int exp_owner[4] = '{0, 2, 0, 2};
    do_reset();
    req = 32'h5;
    for (int i = 0; i < 4; i++) begin
      rel = 1'b0;
      cycle();
      n_cmp++;
      if (grant !== (32'h1 << exp_owner[i]) || grant_id !== 5'(exp_owner[i])) begin
        n_bad++;
        $display("FAIL rr_owner[%0d]: grant=%h id=%0d, expected id %0d",
                 i, grant, grant_id, exp_owner[i]);
      end
      rel = 1'b1;
      cycle();
      n_cmp++;
      if (grant !== 32'h0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_gap[%0d]: grant=%h busy=%b, expected 0/0", i, grant, busy);
      end
    end
    rel = 1'b0;
  endtask

  // Leaves source 23 freshly granted for the following wrap test.
  task automatic test_timeout();
    do_reset();
    req = 32'h0080_0000;
    for (int i = 0; i < HOLD_MAX; i++) begin
      cycle();
      n_cmp++;
      if (grant_id !== 5'd23 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout_hold[%0d]: id=%0d to=%b, expected 23/0", i, grant_id, timeout);
      end
    end
    cycle();
    n_cmp++;
    if (timeout !== 1'b1 || grant !== 32'h0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: to=%b grant=%h busy=%b, expected 1/0/0",
               timeout, grant, busy);
    end
    cycle();
    n_cmp++;
    if (timeout !== 1'b0 || grant_id !== 5'd23) begin
      n_bad++;
      $display("FAIL timeout_regrant: to=%b id=%0d, expected 0/23", timeout, grant_id);
    end
  endtask

  task automatic test_priority_wrap();
    int exp_owner[4] = '{0, 23, 0, 23};
    req = 32'hFF80_0001;
    rel = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      rel = 1'b0;
      cycle();
      n_cmp++;
      if (grant_id !== 5'(exp_owner[i]) || grant[31:24] !== 8'h0) begin
        n_bad++;
        $display("FAIL wrap_owner[%0d]: grant=%h id=%0d, expected id %0d",
                 i, grant, grant_id, exp_owner[i]);
      end
      rel = 1'b1;
      cycle();
    end
    rel = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 32'h80;
    cycle();
    rel = 1'b1;
    cycle();
    rel = 1'b0;
    cycle();
    n_cmp++;
    if (grant_id !== 5'd7) begin
      n_bad++;
      $display("FAIL midreset_setup: id=%0d, expected 7", grant_id);
    end
    clr = 1'b0;
    cycle();
    n_cmp++;
    if (grant !== 32'h0 || timeout !== 1'b0 || grant_id !== 5'd31) begin
      n_bad++;
      $display("FAIL midreset_drop: grant=%h to=%b id=%0d, expected 0/0/31",
               grant, timeout, grant_id);
    end
    clr = 1'b1;
    req = 32'h0000_0FFF;
    cycle();
    n_cmp++;
    if (grant_id !== 5'd0) begin
      n_bad++;
      $display("FAIL midreset_ptr: id=%0d, expected 0", grant_id);
    end
  endtask

  task automatic test_release_at_limit();
    do_reset();
    req = 32'h2;
    for (int i = 0; i < HOLD_MAX; i++) cycle();
    n_cmp++;
    if (grant_id !== 5'd1) begin
      n_bad++;
      $display("FAIL limit_setup: id=%0d, expected 1", grant_id);
    end
    rel = 1'b1;
    cycle();
    rel = 1'b0;
    n_cmp++;
    if (timeout !== 1'b0 || grant !== 32'h0) begin
      n_bad++;
      $display("FAIL limit_release: to=%b grant=%h, expected 0/0", timeout, grant);
    end
    req = 32'h0;
    cycle();
    n_cmp++;
    if (busy !== 1'b0 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL withdraw_idle: busy=%b to=%b, expected 0/0", busy, timeout);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_grant;
    logic [4:0]  exp_id;
    int run = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        req = $urandom & $urandom & $urandom;
        if ($urandom_range(0, 3) == 0) req = 32'h1 << $urandom_range(0, 31);
      end
      rel = ($urandom_range(0, 23) == 0);
      clr = ($urandom_range(0, 299) != 0);
      cycle();
      exp_grant = (m_owner < 0) ? 32'h0 : (32'h1 << m_owner);
      exp_id    = (m_owner < 0) ? 5'd31 : 5'(m_owner);
      n_cmp++;
      if ({grant, grant_id, busy, timeout} !== {exp_grant, exp_id, m_owner >= 0, m_to}) begin
        n_bad++;
        $display("FAIL random[%0d]: grant=%h id=%0d busy=%b to=%b, expected %h/%0d/%b/%b",
                 i, grant, grant_id, busy, timeout, exp_grant, exp_id, m_owner >= 0, m_to);
      end
      run = busy ? run + 1 : 0;
      n_cmp++;
      if (run > HOLD_MAX) begin
        n_bad++;
        $display("FAIL random_hold[%0d]: run=%0d, expected <= %0d", i, run, HOLD_MAX);
      end
    end
    clr = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_priority_wrap();
    test_reset_mid_grant();
    test_release_at_limit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
